// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1-style UART receiver feeding a small
// show-ahead FIFO with a valid/ready pop interface and sticky error flags.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              frame_err,
    output logic                              overrun,
    input  logic                              err_clr
);

    localparam int BCW  = $clog2(CLK_DIV);
    localparam int BITW = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [BCW-1:0]  BC_LAST  = BCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0]  BC_HALF  = BCW'(CLK_DIV / 2 - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_BITS - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t              state, state_nxt;
    logic                rx_p0, rx_s;
    logic [BCW-1:0]      bcnt, bcnt_nxt;
    logic [BITW-1:0]     bit_cnt, bit_cnt_nxt;
    logic                shift_en;
    logic                stop_ok;
    logic                stop_bad;
    logic [DATA_BITS-1:0] shreg;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 ov_set;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // Receiver control registers: state, baud counter, bit counter, busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bcnt    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bcnt    <= bcnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

    // Next-state logic; bcnt restarts at 0 whenever a new state is entered
    always_comb begin
        state_nxt   = state;
        bcnt_nxt    = (bcnt == BC_LAST) ? '0 : bcnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                bcnt_nxt    = '0;
                bit_cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (bcnt == BC_HALF) begin
                    bcnt_nxt  = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bcnt == BC_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bcnt == BC_LAST) begin
                    if (rx_s) begin
                        stop_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                bcnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
            end
        endcase
    end

    // Data shift register, LSB arrives first so bits enter at the top
    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

    assign full   = (count == CNT_FULL);
    assign pop    = rx_valid & rx_ready;
    assign push   = stop_ok & (~full | pop);
    assign ov_set = stop_ok & full & ~pop;

    // FIFO storage; a pop in the same cycle frees the slot for a full push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_bad)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ov_set)       overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;
        end
    end

    assign rx_valid   = (count != '0);
    assign fifo_count = count;
    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;

endmodule
